// File: rtl/cla_serial_subtractor.sv
// cla_serial_subtractor
//   Multi-cycle subtractor producing diff = a - b - bin (mod 2^WIDTH).
//   The subtraction is done as a + ~b + ~bin, one 4-bit carry-look-ahead
//   slice per clock, least-significant nibble first. The carry between
//   nibbles is held in a register. Valid/ready handshakes on both sides.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start_valid  operands a, b, bin are valid
//   start_ready  block can accept operands (IDLE only)
//   a, b         minuend / subtrahend (WIDTH bits)
//   bin          borrow in
//   diff         registered result a - b - bin
//   bout         borrow out (1 = unsigned a < b + bin)
//   ovf          signed two's-complement overflow
//   zero         diff == 0
//   done_valid   result valid, held until done_ready
//   done_ready   consumer accepts result
module cla_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic             done_valid,
    input  logic             done_ready
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
        $error("cla_serial_subtractor: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  nb_q;      // subtrahend stored already inverted
    logic              c_q;       // inter-nibble carry (inverted borrow)
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              bout_q, ovf_q, zero_q;

    // One 4-bit look-ahead slice on the current nibble
    logic [3:0] a_n, nb_n, g, p, sum;
    logic       c1, c2, c3, c4;
    logic       last_nib;

    always_comb begin
        a_n  = a_q[4*idx_q +: 4];
        nb_n = nb_q[4*idx_q +: 4];
        g    = a_n & nb_n;
        p    = a_n ^ nb_n;
        c1   = g[0] | (p[0] & c_q);
        c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_q);
        c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_q);
        c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_q);
        sum  = p ^ {c3, c2, c1, c_q};
    end

    // Full result with the current nibble merged in, so the flags on the
    // final pass see the complete difference in the same cycle.
    always_comb begin
        diff_d               = diff_q;
        diff_d[4*idx_q +: 4] = sum;
    end

    assign last_nib = (idx_q == IDXW'(NIB - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_valid) state_d = RUN;
            RUN:     if (last_nib)    state_d = DONE;
            DONE:    if (done_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        start_ready = (state_q == IDLE);
        done_valid  = (state_q == DONE);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            a_q    <= '0;
            nb_q   <= '0;
            c_q    <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q   <= a;
                        nb_q  <= ~b;
                        c_q   <= ~bin;
                        idx_q <= '0;
                    end
                end
                RUN: begin
                    diff_q <= diff_d;
                    c_q    <= c4;
                    idx_q  <= idx_q + IDXW'(1);
                    if (last_nib) begin
                        bout_q <= ~c4;
                        // Operand signs differ and result sign departs from a
                        ovf_q  <= (a_q[WIDTH-1] != ~nb_q[WIDTH-1]) &&
                                  (diff_d[WIDTH-1] != a_q[WIDTH-1]);
                        zero_q <= (diff_d == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
    assign zero = zero_q;

endmodule
